// File: rtl/edc_controller.sv
// rtl/edc_controller.sv - byte-parity protected bridge between an upstream bus and a memory port
//
// Purpose:
//   Forwards single upstream transfers to memory. Writes carry one even-parity
//   check bit per byte. Read data is checked against the stored check bits on the
//   selected bytes only; a mismatch re-issues the same read up to MAX_RETRY times
//   before the transfer completes with an error.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_wb_*                  upstream request (adr/sel/we/cyc/stb/dat)
//   o_wb_dat/ack/err        upstream response, valid for one cycle
//   o_mem_*                 memory request with write data and check bits
//   i_mem_dat/edc/ack       memory read data, stored check bits, completion
//   i_err_clr               clears error count and sticky flag
//   o_err_count             saturating count of parity mismatches
//   o_err_sticky            set when a read ran out of retries

module edc_controller #(
   parameter int WB_DWIDTH = 32,
   parameter int WB_SWIDTH = 4,
   parameter int MAX_RETRY = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [31:0]          i_wb_adr,
   input  logic [WB_SWIDTH-1:0] i_wb_sel,
   input  logic                 i_wb_we,
   input  logic                 i_wb_cyc,
   input  logic                 i_wb_stb,
   input  logic [WB_DWIDTH-1:0] i_wb_dat,
   output logic [WB_DWIDTH-1:0] o_wb_dat,
   output logic                 o_wb_ack,
   output logic                 o_wb_err,
   output logic [31:0]          o_mem_adr,
   output logic [WB_SWIDTH-1:0] o_mem_sel,
   output logic                 o_mem_we,
   output logic                 o_mem_cyc,
   output logic                 o_mem_stb,
   output logic [WB_DWIDTH-1:0] o_mem_dat,
   output logic [WB_SWIDTH-1:0] o_mem_edc,
   input  logic [WB_DWIDTH-1:0] i_mem_dat,
   input  logic [WB_SWIDTH-1:0] i_mem_edc,
   input  logic                 i_mem_ack,
   input  logic                 i_err_clr,
   output logic [15:0]          o_err_count,
   output logic                 o_err_sticky
);

   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   typedef enum logic [1:0] {IDLE, MEM, CHECK, RESP} state_t;

   state_t                 state_q, state_d;
   logic [31:0]            adr_q, adr_d;
   logic [WB_SWIDTH-1:0]   sel_q, sel_d;
   logic                   we_q, we_d;
   logic [WB_DWIDTH-1:0]   wdat_q, wdat_d;
   logic [WB_DWIDTH-1:0]   rdat_q, rdat_d;
   logic [WB_SWIDTH-1:0]   redc_q, redc_d;
   logic [RW-1:0]          retry_q, retry_d;
   logic                   resp_err_q, resp_err_d;
   logic [15:0]            err_count_q, err_count_d;
   logic                   err_sticky_q, err_sticky_d;
   logic                   mismatch;
   logic                   cnt_inc;
   logic                   sticky_set;

   function automatic logic [WB_SWIDTH-1:0] parity(input logic [WB_DWIDTH-1:0] d);
      logic [WB_SWIDTH-1:0] p;
      p = '0;
      for (int k = 0; k < WB_SWIDTH; k++) begin
         p[k] = ^d[8*k +: 8];
      end
      return p;
   endfunction

   // Only bytes the requester selected can fail the check.
   assign mismatch = |((parity(rdat_q) ^ redc_q) & sel_q);

   always_comb begin
      state_d    = state_q;
      adr_d      = adr_q;
      sel_d      = sel_q;
      we_d       = we_q;
      wdat_d     = wdat_q;
      rdat_d     = rdat_q;
      redc_d     = redc_q;
      retry_d    = retry_q;
      resp_err_d = resp_err_q;
      cnt_inc    = 1'b0;
      sticky_set = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_wb_cyc && i_wb_stb) begin
               adr_d      = i_wb_adr;
               sel_d      = i_wb_sel;
               we_d       = i_wb_we;
               wdat_d     = i_wb_dat;
               retry_d    = '0;
               resp_err_d = 1'b0;
               state_d    = MEM;
            end
         end
         MEM: begin
            if (i_mem_ack) begin
               if (we_q) begin
                  state_d = RESP;
               end else begin
                  rdat_d  = i_mem_dat;
                  redc_d  = i_mem_edc;
                  state_d = CHECK;
               end
            end
         end
         CHECK: begin
            if (mismatch) begin
               cnt_inc = 1'b1;
               if (retry_q < RW'(MAX_RETRY)) begin
                  retry_d = retry_q + RW'(1);
                  state_d = MEM;
               end else begin
                  resp_err_d = 1'b1;
                  sticky_set = 1'b1;
                  state_d    = RESP;
               end
            end else begin
               resp_err_d = 1'b0;
               state_d    = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Clear takes priority over a same-cycle increment or set.
      err_count_d  = err_count_q;
      err_sticky_d = err_sticky_q;
      if (i_err_clr) begin
         err_count_d  = '0;
         err_sticky_d = 1'b0;
      end else begin
         if (cnt_inc && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
         end
         if (sticky_set) begin
            err_sticky_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= IDLE;
         adr_q        <= '0;
         sel_q        <= '0;
         we_q         <= 1'b0;
         wdat_q       <= '0;
         rdat_q       <= '0;
         redc_q       <= '0;
         retry_q      <= '0;
         resp_err_q   <= 1'b0;
         err_count_q  <= '0;
         err_sticky_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         adr_q        <= adr_d;
         sel_q        <= sel_d;
         we_q         <= we_d;
         wdat_q       <= wdat_d;
         rdat_q       <= rdat_d;
         redc_q       <= redc_d;
         retry_q      <= retry_d;
         resp_err_q   <= resp_err_d;
         err_count_q  <= err_count_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   // Outputs are decoded from registered state so reset clears them immediately.
   logic in_mem;
   logic in_resp;
   assign in_mem  = (state_q == MEM);
   assign in_resp = (state_q == RESP);

   assign o_mem_cyc    = in_mem;
   assign o_mem_stb    = in_mem;
   assign o_mem_adr    = in_mem ? adr_q : '0;
   assign o_mem_sel    = in_mem ? sel_q : '0;
   assign o_mem_we     = in_mem & we_q;
   assign o_mem_dat    = in_mem ? wdat_q : '0;
   assign o_mem_edc    = in_mem ? parity(wdat_q) : '0;

   assign o_wb_ack     = in_resp & ~resp_err_q;
   assign o_wb_err     = in_resp & resp_err_q;
   assign o_wb_dat     = (in_resp && !we_q) ? rdat_q : '0;

   assign o_err_count  = err_count_q;
   assign o_err_sticky = err_sticky_q;

endmodule

// File: tb/tb_edc_controller.sv
// tb/tb_edc_controller.sv - directed self-checking bench for edc_controller

module tb_edc_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] wb_adr = '0;
   logic [3:0]  wb_sel = '0;
   logic        wb_we = 1'b0;
   logic        wb_cyc = 1'b0;
   logic        wb_stb = 1'b0;
   logic [31:0] wb_dat_w = '0;
   logic [31:0] wb_dat_r;
   logic        wb_ack;
   logic        wb_err;
   logic [31:0] mem_adr;
   logic [3:0]  mem_sel;
   logic        mem_we;
   logic        mem_cyc;
   logic        mem_stb;
   logic [31:0] mem_dat_w;
   logic [3:0]  mem_edc_w;
   logic [31:0] mem_dat_r = '0;
   logic [3:0]  mem_edc_r = '0;
   logic        mem_ack = 1'b0;
   logic        err_clr = 1'b0;
   logic [15:0] err_count;
   logic        err_sticky;

   int checks = 0;
   int errors = 0;
   int bursts = 0;
   logic prev_stb = 1'b0;

   edc_controller #(.WB_DWIDTH(32), .WB_SWIDTH(4), .MAX_RETRY(2)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_wb_adr    (wb_adr),
      .i_wb_sel    (wb_sel),
      .i_wb_we     (wb_we),
      .i_wb_cyc    (wb_cyc),
      .i_wb_stb    (wb_stb),
      .i_wb_dat    (wb_dat_w),
      .o_wb_dat    (wb_dat_r),
      .o_wb_ack    (wb_ack),
      .o_wb_err    (wb_err),
      .o_mem_adr   (mem_adr),
      .o_mem_sel   (mem_sel),
      .o_mem_we    (mem_we),
      .o_mem_cyc   (mem_cyc),
      .o_mem_stb   (mem_stb),
      .o_mem_dat   (mem_dat_w),
      .o_mem_edc   (mem_edc_w),
      .i_mem_dat   (mem_dat_r),
      .i_mem_edc   (mem_edc_r),
      .i_mem_ack   (mem_ack),
      .i_err_clr   (err_clr),
      .o_err_count (err_count),
      .o_err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   // Counts distinct memory strobe bursts.
   always @(posedge clk) begin
      prev_stb <= mem_stb;
      if (mem_stb && !prev_stb) bursts <= bursts + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents a request for one cycle, then scrambles the upstream inputs.
   // Returns at the negedge where the DUT is in MEM.
   task automatic start_req(input logic we, input logic [31:0] adr,
                            input logic [3:0] sel, input logic [31:0] dat);
      @(negedge clk);
      wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat_w = dat;
      wb_cyc = 1'b1; wb_stb = 1'b1;
      @(negedge clk);
      wb_cyc = 1'b0; wb_stb = 1'b0;
      wb_adr = 32'hDEAD_BEEF; wb_sel = 4'h0; wb_we = ~we; wb_dat_w = 32'h5A5A_5A5A;
   endtask

   // Waits (bounded) for a memory strobe and acknowledges it for one cycle.
   task automatic serve(input logic [31:0] dat, input logic [3:0] edc);
      int n;
      n = 0;
      while (!mem_stb && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!mem_stb) chk("mem_stb_timeout", {31'd0, mem_stb}, 32'd1);
      mem_dat_r = dat; mem_edc_r = edc; mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0; mem_dat_r = '0; mem_edc_r = '0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   // Read that fails parity once and then passes; adds one to the error count.
   task automatic read_retry_once();
      start_req(1'b0, 32'h200, 4'hF, 32'h0);
      serve(32'h0180FF00, 4'b0000);
      @(negedge clk);
      serve(32'h0180FF00, 4'b1100);
      @(negedge clk);
   endtask

   initial begin
      int b0;
      int stray;

      // Reset state
      #12;
      chk("rst_wb_ack", {31'd0, wb_ack}, 32'd0);
      chk("rst_mem_stb", {31'd0, mem_stb}, 32'd0);
      chk("rst_count", {16'd0, err_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Write 0x0180FF00: byte parities b3..b0 = 1,1,0,0
      b0 = bursts;
      start_req(1'b1, 32'h100, 4'hF, 32'h0180FF00);
      chk("wr_mem_stb", {31'd0, mem_stb}, 32'd1);
      chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
      chk("wr_mem_adr", mem_adr, 32'h100);
      chk("wr_mem_dat", mem_dat_w, 32'h0180FF00);
      chk("wr_mem_edc", {28'd0, mem_edc_w}, 32'hC);
      chk("wr_wb_ack_early", {31'd0, wb_ack}, 32'd0);
      serve(32'h0, 4'h0);
      chk("wr_wb_ack", {31'd0, wb_ack}, 32'd1);
      chk("wr_wb_err", {31'd0, wb_err}, 32'd0);
      chk("wr_wb_dat", wb_dat_r, 32'd0);
      chk("wr_resp_stb", {31'd0, mem_stb}, 32'd0);
      @(negedge clk);
      chk("wr_ack_one_cycle", {31'd0, wb_ack}, 32'd0);
      chk("wr_count", {16'd0, err_count}, 32'd0);
      chk("wr_bursts", bursts - b0, 32'd1);

      // Second write pattern: 0x07030100 -> parities 1,0,1,0
      start_req(1'b1, 32'h104, 4'h3, 32'h07030100);
      chk("wr2_mem_edc", {28'd0, mem_edc_w}, 32'hA);
      chk("wr2_mem_sel", {28'd0, mem_sel}, 32'h3);
      serve(32'h0, 4'h0);
      chk("wr2_wb_ack", {31'd0, wb_ack}, 32'd1);

      // Clean read: ack two cycles after the memory ack
      b0 = bursts;
      start_req(1'b0, 32'h100, 4'hF, 32'h0);
      chk("rd_mem_we", {31'd0, mem_we}, 32'd0);
      serve(32'h0180FF00, 4'b1100);
      chk("rd_check_ack", {31'd0, wb_ack}, 32'd0);
      chk("rd_check_stb", {31'd0, mem_stb}, 32'd0);
      @(negedge clk);
      chk("rd_wb_ack", {31'd0, wb_ack}, 32'd1);
      chk("rd_wb_dat", wb_dat_r, 32'h0180FF00);
      chk("rd_bursts", bursts - b0, 32'd1);
      chk("rd_count", {16'd0, err_count}, 32'd0);
      @(negedge clk);
      chk("rd_ack_low", {31'd0, wb_ack}, 32'd0);

      // Unselected byte 3 has wrong check bit: ignored
      b0 = bursts;
      start_req(1'b0, 32'h108, 4'h1, 32'h0);
      serve(32'h0180FF00, 4'b0100);
      @(negedge clk);
      chk("unsel_wb_ack", {31'd0, wb_ack}, 32'd1);
      chk("unsel_bursts", bursts - b0, 32'd1);
      chk("unsel_count", {16'd0, err_count}, 32'd0);

      // Bad on first pass, good on retry
      b0 = bursts;
      start_req(1'b0, 32'h10C, 4'hF, 32'h0);
      serve(32'h0180FF00, 4'b0000);
      @(negedge clk);
      chk("retry_reissue_stb", {31'd0, mem_stb}, 32'd1);
      chk("retry_reissue_adr", mem_adr, 32'h10C);
      serve(32'h0180FF00, 4'b1100);
      @(negedge clk);
      chk("retry_wb_ack", {31'd0, wb_ack}, 32'd1);
      chk("retry_bursts", bursts - b0, 32'd2);
      chk("retry_count", {16'd0, err_count}, 32'd1);
      chk("retry_sticky", {31'd0, err_sticky}, 32'd0);

      pulse_clr();
      chk("clr1_count", {16'd0, err_count}, 32'd0);

      // Persistently bad: three reads then error
      b0 = bursts;
      start_req(1'b0, 32'h110, 4'hF, 32'h0);
      serve(32'h0180FF00, 4'b0011);
      @(negedge clk);
      serve(32'h0180FF00, 4'b0011);
      @(negedge clk);
      serve(32'h0180FF00, 4'b0011);
      @(negedge clk);
      chk("exh_wb_err", {31'd0, wb_err}, 32'd1);
      chk("exh_wb_ack", {31'd0, wb_ack}, 32'd0);
      chk("exh_bursts", bursts - b0, 32'd3);
      chk("exh_count", {16'd0, err_count}, 32'd3);
      chk("exh_sticky", {31'd0, err_sticky}, 32'd1);
      @(negedge clk);
      chk("exh_err_low", {31'd0, wb_err}, 32'd0);
      pulse_clr();
      chk("clr2_count", {16'd0, err_count}, 32'd0);
      chk("clr2_sticky", {31'd0, err_sticky}, 32'd0);

      // Build count to 5, then reset mid-MEM
      for (int i = 0; i < 5; i++) read_retry_once();
      chk("pre_rst_count", {16'd0, err_count}, 32'd5);
      start_req(1'b0, 32'h120, 4'hF, 32'h0);
      chk("pre_rst_mem_stb", {31'd0, mem_stb}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_stb", {31'd0, mem_stb}, 32'd0);
      chk("async_rst_cyc", {31'd0, mem_cyc}, 32'd0);
      chk("async_rst_adr", mem_adr, 32'd0);
      chk("async_rst_count", {16'd0, err_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (wb_ack || wb_err || mem_stb) stray++;
      end
      chk("post_rst_no_resp", stray, 32'd0);

      // Next request proceeds normally
      start_req(1'b1, 32'h130, 4'hF, 32'hFFFFFFFF);
      chk("post_rst_edc", {28'd0, mem_edc_w}, 32'h0);
      serve(32'h0, 4'h0);
      chk("post_rst_ack", {31'd0, wb_ack}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
